mem_access_ctrl: RTL and testbench

Sequencer for instruction fetch and load/store on the shared 16-bit memory address bus. Owns the program counter and drives pc_addr and sel_add_bus into the address-bus mux, which sits directly downstream. Also drives the memory request/write-enable handshake, latches fetched instructions and load data, and applies branch targets. Sits between the decode/register-bank logic and the memory interface.

---
 rtl/mem_access_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Instruction fetch / load-store sequencer for the shared 16-bit memory address bus.
// Owns the PC, runs the mem_req/mem_ready handshake and latches fetched words and load data.
module mem_access_ctrl #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter int                PC_STEP  = 1,
  parameter int                MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              ls_start,
  input  logic              ls_is_store,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc_addr,
  output logic              sel_add_bus,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_valid,
  output logic              busy,
  output logic              mem_fault
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_LS,
    ST_FAULT
  } state_t;

  localparam int                WAIT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;
  localparam logic [ADDR_W-1:0] PC_INC    = ADDR_W'(PC_STEP);

  state_t              state;
  state_t              state_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                wait_expired;
  logic                pend_branch;
  logic [ADDR_W-1:0]   pend_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_next;
    end
  end

  // An unanswered request faults on the cycle the wait counter would reach MAX_WAIT.
  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    sel_add_bus  = 1'b0;
    busy         = 1'b1;
    wait_expired = (MAX_WAIT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);
    case (state)
      ST_RESET: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        busy       = 1'b0;
        state_next = ls_start ? ST_LS : ST_FETCH;
      end
      ST_LS: begin
        mem_req     = 1'b1;
        sel_add_bus = 1'b1;
        if (mem_ready) begin
          state_next = ST_FETCH;
        end else if (wait_expired) begin
          state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_addr     <= RESET_PC;
      ir          <= '0;
      ir_valid    <= 1'b0;
      ld_data     <= '0;
      ld_valid    <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      mem_fault   <= 1'b0;
      wait_cnt    <= '0;
      pend_branch <= 1'b0;
      pend_target <= '0;
    end else begin
      ir_valid <= 1'b0;
      ld_valid <= 1'b0;

      if (mem_req && !mem_ready && (state_next == state)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end

      if (state_next == ST_FAULT) begin
        mem_fault <= 1'b1;
      end

      case (state)
        ST_FETCH: begin
          if (mem_ready) begin
            ir       <= mem_rdata;
            ir_valid <= 1'b1;
            pc_addr  <= pc_addr + PC_INC;
          end
        end
        // A branch arriving alongside a load/store is parked until the access completes.
        ST_DECODE: begin
          if (ls_start) begin
            mem_we      <= ls_is_store;
            mem_wdata   <= ls_wdata;
            pend_branch <= branch_valid;
            pend_target <= branch_target;
          end else if (branch_valid) begin
            pc_addr <= branch_target;
          end
        end
        ST_LS: begin
          if (mem_ready) begin
            if (!mem_we) begin
              ld_data  <= mem_rdata;
              ld_valid <= 1'b1;
            end
            if (pend_branch) begin
              pc_addr <= pend_target;
            end
          end
          if (state_next != ST_LS) begin
            mem_we      <= 1'b0;
            pend_branch <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: fetched words and load results are queued as they are
// driven and popped when ir_valid / ld_valid pulse; other outputs are checked at each step.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ls_start;
  logic        ls_is_store;
  logic [31:0] ls_wdata;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic [15:0] pc_addr;
  logic        sel_add_bus;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] ld_data;
  logic        ld_valid;
  logic        busy;
  logic        mem_fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] ir_q[$];
  logic [31:0] ld_q[$];

  logic [15:0] exp_pc;
  logic        pend;
  logic [15:0] pend_tgt;

  mem_access_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .mem_ready     (mem_ready),
    .mem_rdata     (mem_rdata),
    .ls_start      (ls_start),
    .ls_is_store   (ls_is_store),
    .ls_wdata      (ls_wdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .pc_addr       (pc_addr),
    .sel_add_bus   (sel_add_bus),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .ir            (ir),
    .ir_valid      (ir_valid),
    .ld_data       (ld_data),
    .ld_valid      (ld_valid),
    .busy          (busy),
    .mem_fault     (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input logic [31:0] rdata, input logic ls,
                               input logic st, input logic [31:0] wdata, input logic bv,
                               input logic [15:0] bt);
    mem_ready     = rdy;
    mem_rdata     = rdata;
    ls_start      = ls;
    ls_is_store   = st;
    ls_wdata      = wdata;
    branch_valid  = bv;
    branch_target = bt;
    @(negedge clk);
  endtask

  // Entered at a negedge with the DUT in FETCH; leaves it in DECODE.
  task automatic doFetch(input logic [31:0] rdata, input int stall);
    for (int i = 0; i <= stall; i++) begin
      checkOutput("fetch_req", {31'b0, mem_req}, 32'd1);
      checkOutput("fetch_sel", {31'b0, sel_add_bus}, 32'd0);
      checkOutput("fetch_we", {31'b0, mem_we}, 32'd0);
      checkOutput("fetch_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
      if (i == stall) ir_q.push_back(rdata);
      applyStimulus(i == stall, (i == stall) ? rdata : 32'h0BAD_0BAD, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    exp_pc = exp_pc + 16'd1;
    checkOutput("decode_busy", {31'b0, busy}, 32'd0);
    checkOutput("decode_req", {31'b0, mem_req}, 32'd0);
    checkOutput("decode_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
    checkOutput("decode_ir", ir, rdata);
  endtask

  // mem_ready is held high with junk data during DECODE; the DUT must ignore it.
  task automatic doDecode(input logic ls, input logic st, input logic [31:0] wdata,
                          input logic bv, input logic [15:0] bt);
    if (ls) begin
      if (bv) begin
        pend     = 1'b1;
        pend_tgt = bt;
      end
    end else if (bv) begin
      exp_pc = bt;
    end
    applyStimulus(1'b1, 32'hBAD0_BAD0, ls, st, wdata, bv, bt);
    checkOutput("post_decode_busy", {31'b0, busy}, 32'd1);
    checkOutput("post_decode_sel", {31'b0, sel_add_bus}, {31'b0, ls});
    checkOutput("post_decode_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
  endtask

  // Entered at a negedge with the DUT in LS; leaves it in FETCH.
  task automatic doLs(input logic st, input logic [31:0] wdata, input logic [31:0] rdata, input int stall);
    for (int i = 0; i <= stall; i++) begin
      checkOutput("ls_req", {31'b0, mem_req}, 32'd1);
      checkOutput("ls_sel", {31'b0, sel_add_bus}, 32'd1);
      checkOutput("ls_we", {31'b0, mem_we}, {31'b0, st});
      checkOutput("ls_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
      if (st) checkOutput("ls_wdata", mem_wdata, wdata);
      if (i == stall && !st) ld_q.push_back(rdata);
      applyStimulus(i == stall, (i == stall) ? rdata : 32'h0BAD_F00D, 1'b0, 1'b0, '0, 1'b0, '0);
    end
    if (pend) begin
      exp_pc = pend_tgt;
      pend   = 1'b0;
    end
    checkOutput("ls_exit_sel", {31'b0, sel_add_bus}, 32'd0);
    checkOutput("ls_exit_we", {31'b0, mem_we}, 32'd0);
    checkOutput("ls_exit_req", {31'b0, mem_req}, 32'd1);
    checkOutput("ls_exit_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
    if (!st) checkOutput("ls_ld_data", ld_data, rdata);
  endtask

  always @(negedge clk) begin
    if (ir_valid === 1'b1) begin
      if (ir_q.size() == 0) checkOutput("ir_valid_unexpected", {31'b0, ir_valid}, 32'd0);
      else checkOutput("ir_scoreboard", ir, ir_q.pop_front());
    end
    if (ld_valid === 1'b1) begin
      if (ld_q.size() == 0) checkOutput("ld_valid_unexpected", {31'b0, ld_valid}, 32'd0);
      else checkOutput("ld_scoreboard", ld_data, ld_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req_cycles;
    pend     = 1'b0;
    pend_tgt = '0;
    exp_pc   = 16'h0000;
    rst      = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("rst_pc", {16'b0, pc_addr}, 32'd0);
    checkOutput("rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd1);
    checkOutput("rst_ir", ir, 32'd0);
    checkOutput("rst_ld", ld_data, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_fault", {31'b0, mem_fault}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Plain fetch stream with memory always ready.
    for (int k = 0; k < 3; k++) begin
      doFetch(32'hA000_0001, 0);
      doDecode(1'b0, 1'b0, '0, 1'b0, '0);
    end

    // Load, store with three wait cycles, then load with a concurrent branch.
    doFetch(32'hA000_0002, 0);
    doDecode(1'b1, 1'b0, '0, 1'b0, '0);
    doLs(1'b0, '0, 32'hDEAD_BEEF, 0);
    doFetch(32'hA000_0003, 0);
    doDecode(1'b1, 1'b1, 32'h1234_5678, 1'b0, '0);
    doLs(1'b1, 32'h1234_5678, '0, 3);
    doFetch(32'hA000_0004, 0);
    doDecode(1'b1, 1'b0, '0, 1'b1, 16'h0040);
    doLs(1'b0, '0, 32'h5555_AAAA, 1);

    // Long stalls in consecutive states must not add up to a fault.
    doFetch(32'hA000_0005, 10);
    doDecode(1'b1, 1'b0, '0, 1'b0, '0);
    doLs(1'b0, '0, 32'h0F0F_0F0F, 10);

    // Branch to the top of the address space, then wrap on the next fetch.
    doFetch(32'hA000_0006, 0);
    doDecode(1'b0, 1'b0, '0, 1'b1, 16'hFFFF);
    doFetch(32'hA000_0007, 2);
    checkOutput("pc_wrap", {16'b0, pc_addr}, 32'd0);
    doDecode(1'b0, 1'b0, '0, 1'b0, '0);

    // Reset in the middle of a stalled store.
    doFetch(32'hA000_0008, 0);
    doDecode(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, '0);
    checkOutput("mid_ls_we", {31'b0, mem_we}, 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("ls_rst_req", {31'b0, mem_req}, 32'd0);
    checkOutput("ls_rst_we", {31'b0, mem_we}, 32'd0);
    checkOutput("ls_rst_sel", {31'b0, sel_add_bus}, 32'd0);
    checkOutput("ls_rst_pc", {16'b0, pc_addr}, 32'd0);
    checkOutput("ls_rst_ld_valid", {31'b0, ld_valid}, 32'd0);
    rst    = 1'b0;
    exp_pc = 16'h0000;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);

    // Memory never answers: fault after MAX_WAIT request cycles.
    doFetch(32'hA000_0009, 0);
    doDecode(1'b0, 1'b0, '0, 1'b0, '0);
    mem_ready  = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req !== 1'b1) break;
      req_cycles++;
      @(negedge clk);
    end
    checkOutput("fault_req_cycles", req_cycles, 32'd15);
    checkOutput("fault_flag", {31'b0, mem_fault}, 32'd1);
    checkOutput("fault_busy", {31'b0, busy}, 32'd1);
    checkOutput("fault_sel", {31'b0, sel_add_bus}, 32'd0);
    checkOutput("fault_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA000_00FF, 1'b1, 1'b0, '0, 1'b1, 16'h0010);
    checkOutput("fault_sticky", {31'b0, mem_fault}, 32'd1);
    checkOutput("fault_hold_req", {31'b0, mem_req}, 32'd0);
    checkOutput("fault_hold_pc", {16'b0, pc_addr}, {16'b0, exp_pc});
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("fault_rst_flag", {31'b0, mem_fault}, 32'd0);
    checkOutput("fault_rst_pc", {16'b0, pc_addr}, 32'd0);
    rst    = 1'b0;
    exp_pc = 16'h0000;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    doFetch(32'hA000_0010, 0);
    doDecode(1'b0, 1'b0, '0, 1'b0, '0);

    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
    checkOutput("ir_q_drained", ir_q.size(), 32'd0);
    checkOutput("ld_q_drained", ld_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
